// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with taken-branch redirect and an optional precise overflow trap.
// The overflow trap, its FSM and the epc/cause capture are built only when EX_OVF_TRAP_EN is defined.
module ex_mem_stage #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
  parameter logic [4:0]  OVF_CAUSE   = 5'd12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  input  logic        alu_branch,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_br_target,
  input  logic        in_is_branch,
  input  logic        in_ovf_chk,
  input  logic [4:0]  in_rd,
  input  logic        in_regwrite,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic [31:0] in_store_data,
  input  logic        mem_stall,
  input  logic        exc_ack,
  output logic        out_valid,
  output logic        out_regwrite,
  output logic        out_memread,
  output logic        out_memwrite,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_up,
  output logic        exc_pending,
  output logic [31:0] epc,
  output logic [4:0]  cause
);

  typedef enum logic [1:0] {RUN, TRAP, HOLD} state_t;

  state_t      r_state;
  logic        r_out_valid;
  logic        r_regwrite;
  logic        r_memread;
  logic        r_memwrite;
  logic [31:0] r_result;
  logic [31:0] r_store_data;
  logic [4:0]  r_rd;
  logic        r_redirect_valid;
  logic [31:0] r_redirect_pc;
  logic        r_flush_up;
  logic        r_exc_pending;
  logic [31:0] r_epc;
  logic [4:0]  r_cause;
  logic        w_trap;
  logic        w_unused;

`ifdef EX_OVF_TRAP_EN
  assign w_trap      = in_ovf_chk & alu_ovf;
  assign exc_pending = r_exc_pending;
  assign epc         = r_epc;
  assign cause       = r_cause;
  assign w_unused    = alu_zero;
`else
  assign w_trap      = 1'b0;
  assign exc_pending = 1'b0;
  assign epc         = 32'd0;
  assign cause       = 5'd0;
  assign w_unused    = ^{alu_zero, alu_ovf, in_ovf_chk, r_exc_pending, r_epc, r_cause};
`endif

  // Pulse registers hold through a stall; gating them here makes the pulse replay once the stall lifts.
  assign redirect_valid = r_redirect_valid & ~mem_stall;
  assign flush_up       = r_flush_up & ~mem_stall;
  assign redirect_pc    = r_redirect_pc;
  assign out_valid      = r_out_valid;
  assign out_regwrite   = r_regwrite;
  assign out_memread    = r_memread;
  assign out_memwrite   = r_memwrite;
  assign out_result     = r_result;
  assign out_store_data = r_store_data;
  assign out_rd         = r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= RUN;
      r_out_valid      <= 1'b0;
      r_regwrite       <= 1'b0;
      r_memread        <= 1'b0;
      r_memwrite       <= 1'b0;
      r_result         <= 32'd0;
      r_store_data     <= 32'd0;
      r_rd             <= 5'd0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= 32'd0;
      r_flush_up       <= 1'b0;
      r_exc_pending    <= 1'b0;
      r_epc            <= 32'd0;
      r_cause          <= 5'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (!mem_stall) begin
            r_out_valid      <= 1'b0;
            r_regwrite       <= 1'b0;
            r_memread        <= 1'b0;
            r_memwrite       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_flush_up       <= 1'b0;
            if (in_valid) begin
              if (w_trap) begin
                r_state          <= TRAP;
                r_epc            <= in_pc;
                r_cause          <= OVF_CAUSE;
                r_exc_pending    <= 1'b1;
                r_redirect_valid <= 1'b1;
                r_redirect_pc    <= TRAP_VECTOR;
                r_flush_up       <= 1'b1;
              end else begin
                r_out_valid  <= 1'b1;
                r_result     <= alu_r;
                r_store_data <= in_store_data;
                r_rd         <= in_rd;
                // Branches never write back or touch memory, taken or not.
                if (in_is_branch) begin
                  if (alu_branch) begin
                    r_redirect_valid <= 1'b1;
                    r_redirect_pc    <= in_br_target;
                    r_flush_up       <= 1'b1;
                  end
                end else begin
                  r_regwrite <= in_regwrite;
                  r_memread  <= in_memread;
                  r_memwrite <= in_memwrite;
                end
              end
            end
          end
        end
        TRAP: begin
          if (!mem_stall) begin
            r_state          <= HOLD;
            r_redirect_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (exc_ack) begin
            r_state       <= RUN;
            r_exc_pending <= 1'b0;
            r_flush_up    <= 1'b0;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
